ir_prefetch: RTL and testbench

IR_PREFETCH -- requirements
Module: ir_prefetch

---
 rtl/ir_prefetch.sv | 95 +++++++++
 tb/tb_ir_prefetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_prefetch.sv
// Instruction prefetch queue feeding an IR: circular FIFO of DEPTH words, 1-cycle push-to-visible and 1-cycle pop latency.
// Backpressure: in_ready = !full; words offered while full are dropped and latch the sticky ovf flag.
module ir_prefetch #(
  parameter int OPC_W = 4,
  parameter int OPR_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OPC_W+OPR_W-1:0]   instruction_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ir_load,
  input  logic                     ir_enable,
  input  logic                     flush,
  output logic [OPC_W-1:0]         ir_opcode,
  output logic [OPR_W-1:0]         ir_operand,
  output logic                     ir_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [OPR_W-1:0] opr;
  } instr_t;

  instr_t           mem [DEPTH];
  instr_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OPR_W-1:0] operand_q;
  logic             push;
  logic             pop;

  // Status is decoded from the registered count only, never from the request inputs.
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;

  assign push = in_valid && !full;
  assign pop  = ir_load && !empty;
  assign head = mem[rd_ptr];

  assign ir_operand = ir_enable ? operand_q : {OPR_W{1'bz}};

  // Storage is not reset; only pointers and count define what is queued.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= instruction_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ir_opcode <= '0;
      operand_q <= '0;
      ir_valid  <= 1'b0;
      ovf       <= 1'b0;
    end else if (flush) begin
      // IR fields are deliberately kept so a restart can still inspect the last word.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        ir_opcode <= head.opc;
        operand_q <= head.opr;
        ir_valid  <= 1'b1;
      end else if (ir_load) begin
        ir_valid <= 1'b0;
      end
      if (in_valid && full)
        ovf <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_prefetch.sv
// Scoreboard bench for ir_prefetch: a queue-based reference model drives expectations, a monitor checks loaded IR words.
module tb_ir_prefetch;
  localparam int OPC_W = 4;
  localparam int OPR_W = 4;
  localparam int DEPTH = 4;
  localparam int W     = OPC_W + OPR_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [W-1:0]     instruction_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ir_load = 1'b0;
  logic             ir_enable = 1'b0;
  logic             flush = 1'b0;
  logic [OPC_W-1:0] ir_opcode;
  wire  [OPR_W-1:0] ir_operand;
  logic             ir_valid;
  logic [$clog2(DEPTH):0] count;
  logic             empty;
  logic             full;
  logic             ovf;

  ir_prefetch #(.OPC_W(OPC_W), .OPR_W(OPR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instruction_in(instruction_in), .in_valid(in_valid),
    .in_ready(in_ready), .ir_load(ir_load), .ir_enable(ir_enable), .flush(flush),
    .ir_opcode(ir_opcode), .ir_operand(ir_operand), .ir_valid(ir_valid),
    .count(count), .empty(empty), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_ir = '0;
  logic         m_valid = 1'b0;
  logic         m_ovf = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"},    int'(count),    mq.size());
    check({tag, "_empty"},    int'(empty),    int'(mq.size() == 0));
    check({tag, "_full"},     int'(full),     int'(mq.size() == DEPTH));
    check({tag, "_in_ready"}, int'(in_ready), int'(mq.size() != DEPTH));
    check({tag, "_ovf"},      int'(ovf),      int'(m_ovf));
    check({tag, "_ir_valid"}, int'(ir_valid), int'(m_valid));
    check({tag, "_opcode"},   int'(ir_opcode), int'(m_ir[W-1 -: OPC_W]));
    if (ir_enable)
      check({tag, "_operand"}, int'(ir_operand), int'(m_ir[OPR_W-1:0]));
  endtask

  // One clock cycle: drive at negedge, advance model, sample 1ns after the rising edge.
  task automatic step(input logic iv, input logic [W-1:0] word, input logic ld,
                      input logic en, input logic fl, input string tag);
    bit push_ok, pop_ok;
    @(negedge clk);
    in_valid = iv; instruction_in = word; ir_load = ld; ir_enable = en; flush = fl;
    if (fl) begin
      mq.delete();
      m_valid = 1'b0;
      m_ovf = 1'b0;
    end else begin
      push_ok = iv && (mq.size() < DEPTH);
      pop_ok  = ld && (mq.size() > 0);
      if (iv && mq.size() == DEPTH) m_ovf = 1'b1;
      if (pop_ok) begin
        m_ir = mq.pop_front();
        m_valid = 1'b1;
        exp_q.push_back(m_ir);
      end else if (ld) begin
        m_valid = 1'b0;
      end
      if (push_ok) mq.push_back(word);
    end
    @(posedge clk);
    #1;
    check_status(tag);
  endtask

  // Monitor: every edge that sampled a load and left ir_valid set must match the next expected word.
  initial begin
    logic ld_s, fl_s, rs_s;
    logic [W-1:0] w;
    forever begin
      @(posedge clk);
      ld_s = ir_load; fl_s = flush; rs_s = reset;
      #1;
      if (ld_s && !fl_s && rs_s && ir_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mon_unexpected_load: got opcode 0x%0h, expected no load", ir_opcode);
        end else begin
          w = exp_q.pop_front();
          check("mon_opcode", int'(ir_opcode), int'(w[W-1 -: OPC_W]));
          if (ir_enable) check("mon_operand", int'(ir_operand), int'(w[OPR_W-1:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] wd;
    bit iv, ld, en, fl;
    int pv, pl;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_ovf", int'(ovf), 0);
    check("rst_ir_valid", int'(ir_valid), 0);
    check("rst_opcode", int'(ir_opcode), 0);
    reset = 1'b1;

    // Basic push, load and operand drive
    step(1, 8'h3A, 0, 0, 0, "b_push1");
    step(1, 8'h5C, 0, 0, 0, "b_push2");
    step(0, 8'h00, 1, 0, 0, "b_load");
    check("b_opcode3", int'(ir_opcode), 3);
    check("b_count1", int'(count), 1);
    step(0, 8'h00, 0, 1, 0, "b_enable");
    check("b_operandA", int'(ir_operand), 4'hA);
    step(0, 8'h00, 1, 0, 0, "b_drain");

    // Fill to full, overflow, drain in order
    for (int i = 1; i <= 4; i++) step(1, W'(8'h11 * i), 0, 0, 0, "f_fill");
    check("f_full", int'(full), 1);
    check("f_in_ready", int'(in_ready), 0);
    step(1, 8'h55, 0, 0, 0, "f_ovf");
    check("f_ovf_set", int'(ovf), 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 8'h00, 1, 1, 0, "f_pop");
      check("f_pop_opcode", int'(ir_opcode), i);
    end
    check("f_empty", int'(empty), 1);

    // Concurrent push/pop with occupancy held at two
    step(1, 8'h01, 0, 0, 0, "w_pre1");
    step(1, 8'h02, 0, 0, 0, "w_pre2");
    for (int i = 3; i <= 10; i++) begin
      step(1, W'(i), 1, 1, 0, "w_pp");
      check("w_count_held", int'(count), 2);
    end
    step(0, 8'h00, 1, 1, 0, "w_drain");
    step(0, 8'h00, 1, 1, 0, "w_drain");

    // Load on empty after the last word
    step(1, 8'h7E, 0, 0, 0, "e_push");
    step(0, 8'h00, 1, 0, 0, "e_load");
    step(0, 8'h00, 1, 0, 0, "e_load_empty");
    check("e_opcode7", int'(ir_opcode), 7);
    check("e_valid0", int'(ir_valid), 0);

    // Flush beats push and load; IR is retained (ovf still set from the overflow above)
    for (int i = 0; i < 3; i++) step(1, W'(8'h90 + i), 0, 0, 0, "x_fill");
    step(1, 8'hF1, 1, 1, 0, "x_load");
    step(1, 8'hF2, 1, 1, 0, "x_fill4");
    step(1, 8'hF3, 0, 0, 0, "x_ovf");
    step(0, 8'h00, 1, 0, 0, "x_pop");
    step(1, 8'hAB, 1, 1, 1, "x_flush");
    check("x_count0", int'(count), 0);
    check("x_opcode_kept", int'(ir_opcode), 4'h9);
    step(0, 8'h00, 0, 0, 0, "x_idle");

    // Randomised traffic with shifting push/load bias
    for (int i = 0; i < 1500; i++) begin
      pv = (i / 250) % 3;
      pl = 2 - pv;
      wd = W'($urandom);
      iv = ($urandom_range(0, 3) <= pv + 1);
      ld = ($urandom_range(0, 3) <= pl);
      en = $urandom_range(0, 1) == 1;
      fl = $urandom_range(0, 63) == 0;
      step(iv, wd, ld, en, fl, "rnd");
    end

    // Asynchronous reset between edges with three words queued
    step(1, 8'hC1, 0, 0, 1, "a_flush");
    for (int i = 0; i < 3; i++) step(1, W'(8'hC1 + i), 0, 0, 0, "a_fill");
    @(negedge clk);
    in_valid = 0; ir_load = 0; ir_enable = 0; flush = 0;
    #2 reset = 1'b0;
    #1;
    mq.delete(); m_ir = '0; m_valid = 1'b0; m_ovf = 1'b0;
    check_status("a_rst");
    #1 reset = 1'b1;
    step(1, 8'hD4, 0, 0, 0, "a_first_push");
    step(0, 8'h00, 1, 1, 0, "a_load");

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
